// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one single-slave Wishbone port among N masters.
// Define WB_ARB_TIMEOUT_EN to release the bus when the slave never acks.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_i,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [WB_DATA_WIDTH-1:0]               m_dat_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_o,
    input  logic                                   s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   timeout_o
);

    localparam int LW = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [LW-1:0]          last_q;
    logic [LW-1:0]          win_d;
    logic                   any_req;
    logic                   busy;
    logic                   expire;
    int                     sel_idx;

    assign busy = (state_q == BUSY);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    // cnt_q counts finished BUSY cycles, so expiry lands in the TIMEOUT-th one
    assign expire = busy && !s_ack_i &&
                    (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    // First requester at or after last+1, wrapping at NUM_MASTERS
    always_comb begin
        win_d   = last_q;
        any_req = 1'b0;
        sel_idx = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            sel_idx = int'(last_q) + i;
            if (sel_idx >= NUM_MASTERS) begin
                sel_idx = sel_idx - NUM_MASTERS;
            end
            if (!any_req && m_stb_i[sel_idx]) begin
                win_d   = LW'(sel_idx);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
`ifdef WB_ARB_TIMEOUT_EN
        if (rst_i || state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!s_ack_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
`endif
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_MASTERS - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= BUSY;
                        grant_q <= NUM_MASTERS'(1) << win_d;
                        last_q  <= win_d;
                    end
                end
                BUSY: begin
                    if (s_ack_i || expire) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // last_q holds the granted index for the whole BUSY phase
    assign grant_o   = grant_q;
    assign timeout_o = expire;
    assign s_stb_o   = busy && !s_ack_i;
    assign s_we_o    = busy && m_we_i[last_q];
    assign s_adr_o   = busy ?
        m_adr_i[int'(last_q)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] : '0;
    assign s_dat_o   = busy ?
        m_dat_i[int'(last_q)*WB_DATA_WIDTH +: WB_DATA_WIDTH] : '0;
    assign m_ack_o   = (busy && (s_ack_i || expire)) ? grant_q : '0;
    assign m_dat_o   = expire ? '1 : s_dat_i;

endmodule
